// File: rtl/avr_sample_spi_master_if.sv
// Handshake and SPI pin bundle for avr_sample_spi_master.
// The master modport is the DUT side; slave is the side that drives start and spi_miso.
interface avr_sample_spi_master_if;
    logic        start;
    logic [9:0]  sample_in;
    logic [3:0]  channel_in;
    logic        busy;
    logic        done;
    logic [15:0] miso_data;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_ss;
    logic        spi_miso;

    modport master (
        input  start, sample_in, channel_in, spi_miso,
        output busy, done, miso_data, spi_sck, spi_mosi, spi_ss
    );

    modport slave (
        output start, sample_in, channel_in, spi_miso,
        input  busy, done, miso_data, spi_sck, spi_mosi, spi_ss
    );
endinterface

// File: rtl/avr_sample_spi_master.sv
// SPI mode-0 master that sends one {sample, channel} frame per accepted start.
// Define AVR_SPI_MISO_CAPTURE_EN to capture spi_miso into miso_data; otherwise it reads 0.
module avr_sample_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int SS_SETUP = 2,
    parameter int SS_GAP   = 4
) (
    input logic                     clk,
    input logic                     rst,
    avr_sample_spi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
    localparam logic [15:0] GAP_LAST   = 16'(SS_GAP - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  bit_cnt;
    logic [15:0] frame;
    logic        busy_q, done_q, sck_q, mosi_q, ss_q;
`ifdef AVR_SPI_MISO_CAPTURE_EN
    logic [15:0] cap_q, miso_q;
`endif

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch below sees the values from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ss_q    <= 1'b1;
`ifdef AVR_SPI_MISO_CAPTURE_EN
            cap_q   <= '0;
            miso_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        frame   <= {bus.sample_in[7:0], bus.channel_in, 2'b00, bus.sample_in[9:8]};
                        mosi_q  <= bus.sample_in[7];
                        bit_cnt <= 4'd15;
                        cnt     <= '0;
                        ss_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
`ifdef AVR_SPI_MISO_CAPTURE_EN
                            cap_q <= {cap_q[14:0], bus.spi_miso};
`endif
                        end else begin
                            sck_q <= 1'b0;
                            // Falling edge: present the next bit, or finish after bit 0.
                            if (bit_cnt == 4'd0) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                                mosi_q  <= frame[bit_cnt - 4'd1];
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt == DIV_LAST) begin
                        cnt    <= '0;
                        ss_q   <= 1'b1;
                        mosi_q <= 1'b0;
`ifdef AVR_SPI_MISO_CAPTURE_EN
                        miso_q <= cap_q;
`endif
                        state  <= GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.spi_sck  = sck_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_ss   = ss_q;
`ifdef AVR_SPI_MISO_CAPTURE_EN
    assign bus.miso_data = miso_q;
`else
    assign bus.miso_data = 16'h0000;
`endif
endmodule

// File: doc/avr_sample_spi_master.md
# avr_sample_spi_master

SPI master that drives the AVR-side end of the ADC sample link: it serialises one 10-bit ADC sample plus its 4-bit channel into the two-byte frame consumed by the FPGA sample receiver. It is used as the bench/loopback stimulus for the sample path and as the producer when one board emulates the AVR for another. The block is a single start/busy/done transaction engine with programmable SCK rate and slave-select framing.

## Interface
- CLK_DIV, 4: SCK half-period in clk cycles (≥2).
- SS_SETUP, 2: clk cycles spi_ss is low before the first SCK edge (≥1).
- SS_GAP, 4: clk cycles spi_ss is held high after a frame before done (≥1).

- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one frame; accepted only when busy=0.
- sample_in  input  10  sample latched on accepted start.
- channel_in  input  4  channel latched on accepted start.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse on frame completion.
- miso_data  output  16  bits captured on spi_miso during the last frame, first bit in [15].
- spi_sck  output  1  SPI clock, mode 0 (idle low).
- spi_mosi  output  1  SPI data out, MSB first.
- spi_ss  output  1  active-low slave select.
- spi_miso  input  1  SPI data in.

## Operation
- Frame word F = {sample[7:0], channel, 2'b00, sample[9:8]}; shifted F[15] first. Byte 0 = sample LSBs, byte 1 = channel/MSBs.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: ss=1, sck=0, mosi=0. start=1 latches F, loads bit counter=15, goes to SETUP.
- SETUP: ss=0, mosi=F[15], SS_SETUP cycles.
- SHIFT: 16 bits; per bit sck low CLK_DIV cycles then high CLK_DIV cycles. spi_miso is sampled into the shift register on the clk cycle sck rises. On each falling edge the next bit is driven onto mosi; after bit 0's high phase sck returns low and the state goes to HOLD.
- HOLD: ss=0, sck=0, CLK_DIV cycles (slave detects last byte before ss rises).
- GAP: ss=1, SS_GAP cycles; miso_data updated from shift register on entry.
- Return to IDLE: done=1 for that one cycle, busy=0.
- start while busy: ignored, no queueing. start in the done cycle: accepted (busy is already 0).
- Reset values: busy=0, done=0, spi_ss=1, spi_sck=0, spi_mosi=0, miso_data=16'h0000, state IDLE. Reset mid-frame aborts immediately; ss rises asynchronously; no done pulse.
- Inputs sample_in/channel_in changing during a frame have no effect.

## Timing
- Accepted start at cycle 0: ss falls and busy rises at cycle 1.
- First sck rising edge at cycle 1+SS_SETUP+CLK_DIV.
- done at cycle 1+SS_SETUP+32·CLK_DIV+CLK_DIV+SS_GAP (139 with defaults); ss rises at done−SS_GAP.
- All outputs registered; no combinational path from inputs to outputs.
- Back-to-back frames: minimum start-to-start spacing equals the done latency.

## Configuration
- AVR_SPI_MISO_CAPTURE_EN defined: spi_miso is sampled and miso_data updated per frame as above.
- Not defined: capture shift register removed, spi_miso ignored, miso_data constant 16'h0000; all other timing identical.

## Test plan
- Defaults, start with sample_in=10'h2A5, channel_in=4'h9 -> slave model receives bytes 8'hA5 then 8'h92; done at cycle 139; busy high cycles 1–138.
- spi_miso tied 1 (capture enabled) -> miso_data=16'hFFFF after done; with macro undefined -> miso_data stays 16'h0000.
- spi_miso driven 16'hC3A5 MSB first on sck falling edges -> miso_data=16'hC3A5.
- start held high continuously -> frames back-to-back every 139 cycles, start pulses during busy ignored, ss high ≥4 cycles between frames.
- rst asserted at cycle 60 mid-SHIFT -> ss=1, sck=0, busy=0 same cycle, no done; next start produces a full, correct frame.
- CLK_DIV=2, SS_SETUP=1, SS_GAP=1, sample 10'h3FF, channel 4'hF -> bytes 8'hFF, 8'hF3; done at cycle 1+1+64+2+1=69.
